// File: rtl/run_controller_pkg.sv
// Shared definitions for the CPU run controller: FSM state codes as shown
// on the board LEDs, the LED bit positions of the state field, and a helper
// that tells whether a given state lets the CPU commit cycles.
package run_controller_pkg;

  localparam logic [1:0] ST_PAUSE     = 2'b00;
  localparam logic [1:0] ST_RUN       = 2'b01;
  localparam logic [1:0] ST_STEP_WAIT = 2'b10;
  localparam logic [1:0] ST_HALTED    = 2'b11;

  // LED index mapping of the two state bits
  localparam int LED_STATE_LO = 0;
  localparam int LED_STATE_HI = 1;

  typedef enum logic [1:0] {
    S_PAUSE     = ST_PAUSE,
    S_RUN       = ST_RUN,
    S_STEP_WAIT = ST_STEP_WAIT,
    S_HALTED    = ST_HALTED
  } runState_t;

  // The CPU clock is enabled while free-running or waiting for a step tick
  function automatic logic enableFor(input runState_t s);
    return (s == S_RUN) || (s == S_STEP_WAIT);
  endfunction

endpackage

// File: rtl/run_controller_input_debouncer.sv
// Input conditioning for one raw board input: a two-flop synchroniser
// followed by a debouncer that only accepts a new level after it has been
// seen continuously, plus a registered one-clock pulse on a rising edge of
// the accepted level.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic stable,
  output logic rise_p
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cntInc;
  logic             accept;

  assign cntInc = cnt_q + CNT_W'(1);
  assign accept = (sync2_q != stable_q) && (cntInc == LAST_CNT);

  // Bring the asynchronous raw level into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Count disagreement cycles; adopt the new level once it has persisted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      rise_q <= accept & sync2_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cntInc;
      end
    end
  end

  assign stable = stable_q;
  assign rise_p = rise_q;

endmodule

// File: rtl/run_controller.sv
// Board-level CPU run control: debounces the run, step and speed inputs,
// sequences pause / free-run / single-step, drives the CPU clock-enable and
// the fast/slow select, and counts committed CPU cycles.
// Optional feature macro: RUN_CTRL_HALT_EN -- when defined, a halt request
// coinciding with a CPU tick parks the controller in HALTED until reset.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        sw_speed,
  input  logic        cpu_tick,
  input  logic        halt,
  output logic        frequency,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  runState_t   state_q;
  runState_t   state_d;
  logic        cpuEn_q;
  logic        frequency_q;
  logic [31:0] cycleCnt_q;

  logic runStable;
  logic runPulse;
  logic stepStable;
  logic stepPulse;
  logic speedStable;
  logic speedRise;
  logic haltHit;
  logic unusedBits;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(btn_run),
    .stable(runStable),
    .rise_p(runPulse)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(btn_step),
    .stable(stepStable),
    .rise_p(stepPulse)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_speed_db (
    .clk   (clk),
    .rst   (rst),
    .raw_in(sw_speed),
    .stable(speedStable),
    .rise_p(speedRise)
  );

`ifdef RUN_CTRL_HALT_EN
  assign haltHit    = halt & cpu_tick;
  assign unusedBits = runStable ^ stepStable ^ speedRise;
`else
  assign haltHit    = 1'b0;
  assign unusedBits = runStable ^ stepStable ^ speedRise ^ halt;
`endif

  // Next-state rules; halt beats run, run beats step, run beats a step tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PAUSE: begin
        if (runPulse)       state_d = S_RUN;
        else if (stepPulse) state_d = S_STEP_WAIT;
      end
      S_RUN: begin
        if (haltHit)       state_d = S_HALTED;
        else if (runPulse) state_d = S_PAUSE;
      end
      S_STEP_WAIT: begin
        if (haltHit)       state_d = S_HALTED;
        else if (runPulse) state_d = S_RUN;
        else if (cpu_tick) state_d = S_PAUSE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_PAUSE;
    endcase
  end

  // State and clock-enable move together so cpu_en never lags the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PAUSE;
      cpuEn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpuEn_q <= enableFor(state_d);
    end
  end

  // Speed select follows the debounced switch in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frequency_q <= 1'b0;
    else     frequency_q <= speedStable;
  end

  // Count every CPU tick that the CPU actually commits; wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cycleCnt_q <= '0;
    else if (cpu_tick && cpuEn_q) cycleCnt_q <= cycleCnt_q + 32'd1;
  end

  assign state[LED_STATE_HI:LED_STATE_LO] = state_q;
  assign cpu_en    = cpuEn_q;
  assign frequency = frequency_q;
  assign cycle_cnt = cycleCnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller with a short debounce window.
// Directed table, hand-timed corner sequences, then random stimulus
// checked against a window-based behavioural model.
module tb_run_controller;

  localparam int D  = 4;
  localparam int CW = 3;
`ifdef RUN_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        btnRun, btnStep, swSpeed, cpuTick, halt;
  logic        frequency, cpuEn;
  logic [1:0]  state;
  logic [31:0] cycleCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btnRun),
    .btn_step (btnStep),
    .sw_speed (swSpeed),
    .cpu_tick (cpuTick),
    .halt     (halt),
    .frequency(frequency),
    .cpu_en   (cpuEn),
    .state    (state),
    .cycle_cnt(cycleCnt)
  );

  typedef struct {
    string       name;
    logic        r, s, sp, t, h;
    int          hold;
    logic [1:0]  st;
    logic        en, fr;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int          mState;
  bit          mEn, mFreq;
  logic [31:0] mCnt;
  bit          runSt, stepSt, spdSt, runP, stepP;
  bit          hR[$], hS[$], hP[$];

  task automatic applyStimulus(input logic r, s, sp, t, h);
    btnRun  = r;
    btnStep = s;
    swSpeed = sp;
    cpuTick = t;
    halt    = h;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expSt,
                             input logic expEn, input logic expFr,
                             input logic [31:0] expCnt);
    checks++;
    if (state !== expSt || cpuEn !== expEn || frequency !== expFr || cycleCnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b en=%b freq=%b cnt=%0d, want state=%b en=%b freq=%b cnt=%0d",
               name, state, cpuEn, frequency, cycleCnt, expSt, expEn, expFr, expCnt);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic addVec(input string n, input logic r, s, sp, t, h, input int hold,
                        input logic [1:0] st, input logic en, fr, input logic [31:0] cnt);
    vec_t v;
    v.name = n; v.r = r; v.s = s; v.sp = sp; v.t = t; v.h = h; v.hold = hold;
    v.st = st; v.en = en; v.fr = fr; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic modelReset();
    mState = 0; mEn = 0; mFreq = 0; mCnt = 0;
    runSt = 0; stepSt = 0; spdSt = 0; runP = 0; stepP = 0;
    hR = {}; hS = {}; hP = {};
    for (int i = 0; i < D + 1; i++) begin
      hR.push_back(1'b0); hS.push_back(1'b0); hP.push_back(1'b0);
    end
  endtask

  // A level is accepted once the D-1 oldest synchronised samples all disagree
  function automatic bit flips(input bit h[$], input bit st);
    for (int i = 0; i < D - 1; i++) if (h[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelStep(input bit r, s, sp, t, h);
    int nxt;
    nxt = mState;
    case (mState)
      0: if (runP) nxt = 1; else if (stepP) nxt = 2;
      1: if (HALT_EN && h && t) nxt = 3; else if (runP) nxt = 0;
      2: if (HALT_EN && h && t) nxt = 3; else if (runP) nxt = 1; else if (t) nxt = 0;
      default: nxt = mState;
    endcase
    if (t && mEn) mCnt = mCnt + 32'd1;
    mFreq  = spdSt;
    mState = nxt;
    mEn    = (nxt == 1) || (nxt == 2);
    hR.push_back(r);  void'(hR.pop_front());
    hS.push_back(s);  void'(hS.pop_front());
    hP.push_back(sp); void'(hP.pop_front());
    runP = 0; stepP = 0;
    if (flips(hR, runSt))  begin runSt  = ~runSt;  runP  = runSt;  end
    if (flips(hS, stepSt)) begin stepSt = ~stepSt; stepP = stepSt; end
    if (flips(hP, spdSt))  spdSt = ~spdSt;
  endtask

  initial begin
    int  hold[3];
    bit  lvl[3];
    bit  t, h;

    // Directed table: spec scenarios in one continuous run
    addVec("reset",        0,0,0,0,0,  2, 2'b00,0,0,0);
    addVec("glitch_on",    1,0,0,0,0,  1, 2'b00,0,0,0);
    addVec("glitch_off",   0,0,0,0,0,  8, 2'b00,0,0,0);
    addVec("run_press",    1,0,0,0,0, 10, 2'b01,1,0,0);
    addVec("run_release",  0,0,0,0,0,  8, 2'b01,1,0,0);
    addVec("ticks5",       0,0,0,1,0,  5, 2'b01,1,0,5);
    addVec("ticks_idle",   0,0,0,0,0,  2, 2'b01,1,0,5);
    addVec("pause_press",  1,0,0,0,0, 10, 2'b00,0,0,5);
    addVec("pause_rel",    0,0,0,0,0,  8, 2'b00,0,0,5);
    addVec("step_press",   0,1,0,0,0, 10, 2'b10,1,0,5);
    addVec("step_release", 0,0,0,0,0,  8, 2'b10,1,0,5);
    addVec("step_ticks",   0,0,0,1,0,  3, 2'b00,0,0,6);
    addVec("step_idle",    0,0,0,0,0,  2, 2'b00,0,0,6);
    addVec("speed_on",     0,0,1,0,0, 10, 2'b00,0,1,6);
    addVec("both_press",   1,1,1,0,0, 10, 2'b01,1,1,6);
    addVec("both_release", 0,0,1,0,0,  8, 2'b01,1,1,6);
`ifdef RUN_CTRL_HALT_EN
    addVec("halt_tick",    0,0,1,1,1,  1, 2'b11,0,1,7);
    addVec("halt_idle",    0,0,1,0,0,  2, 2'b11,0,1,7);
    addVec("run_in_halt",  1,0,1,0,0, 10, 2'b11,0,1,7);
    addVec("halt_rel",     0,0,1,0,0,  8, 2'b11,0,1,7);
    addVec("speed_off",    0,0,0,0,0, 10, 2'b11,0,0,7);
`else
    addVec("halt_tick",    0,0,1,1,1,  1, 2'b01,1,1,7);
    addVec("halt_idle",    0,0,1,0,0,  2, 2'b01,1,1,7);
    addVec("run_in_halt",  1,0,1,0,0, 10, 2'b00,0,1,7);
    addVec("halt_rel",     0,0,1,0,0,  8, 2'b00,0,1,7);
    addVec("speed_off",    0,0,0,0,0, 10, 2'b00,0,0,7);
`endif

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].s, vecs[i].sp, vecs[i].t, vecs[i].h);
      repeat (vecs[i].hold) @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].st, vecs[i].en, vecs[i].fr, vecs[i].cnt);
    end

    // Exact press latency for run and speed
    doReset();
    applyStimulus(1, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    checkOutput("lat5", 2'b00, 0, 0, 0);
    @(negedge clk);
    checkOutput("lat6", 2'b01, 1, 1, 0);

    // Single step commits exactly one cycle; reset mid-step discards it
    doReset();
    applyStimulus(0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    checkOutput("step_enter", 2'b10, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("step_one", 2'b00, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    checkOutput("step_again", 2'b10, 1, 0, 1);
    #2;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_midstep", 2'b00, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    checkOutput("post_rst", 2'b00, 0, 0, 0);

    // Run press coinciding with the step tick: go to RUN and count the tick
    doReset();
    applyStimulus(0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    applyStimulus(1, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("run_tick_step", 2'b01, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // Random stimulus against the behavioural model
    doReset();
    modelReset();
    for (int k = 0; k < 3; k++) begin hold[k] = 0; lvl[k] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
        modelReset();
        for (int k = 0; k < 3; k++) begin hold[k] = 0; lvl[k] = 0; end
      end
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          lvl[k]  = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 9);
        end else begin
          hold[k]--;
        end
      end
      t = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 15) == 0);
      applyStimulus(lvl[0], lvl[1], lvl[2], t, h);
      @(posedge clk);
      modelStep(lvl[0], lvl[1], lvl[2], t, h);
      @(negedge clk);
      checkOutput("random", 2'(mState), mEn, mFreq, mCnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
